mul52_rr_sched: RTL and testbench
=================================

Name: mul52_rr_sched

Overview:
Round-robin scheduler that shares one 52x52 signed sequential multiplier (9-pass DSP partial-product engine) between N_REQ requesters. Arbitrates requests and drives the multiplier's i_en/i_a/i_b. Issues back-to-back operations as soon as the multiplier signals input-ready. Tags each in-flight operation with its requester ID and routes the 103-bit product back to the owning requester.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, requester index width, equal to clog2(N_REQ)
TAG_DEPTH, 2, depth of the in-flight tag FIFO; at most 2 operations are in flight

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_req  in  N_REQ  per-requester request level; held with operands until grant
i_a_bus  in  52*N_REQ  signed operand A per requester; slice k = [52k+51:52k]
i_b_bus  in  52*N_REQ  signed operand B per requester, same slicing
o_gnt  out  N_REQ  one-hot, one-cycle grant pulse
o_c  out  103  signed product, shared by all requesters
o_c_vld  out  N_REQ  one-hot, one-cycle result strobe qualifying o_c
o_busy  out  1  high while any operation is in flight
o_err  out  1  sticky; set on a result strobe arriving with the tag FIFO empty
o_mul_en  out  1  multiplier start pulse
o_mul_a  out  52  multiplier operand A
o_mul_b  out  52  multiplier operand B
i_mul_in_en  in  1  multiplier input-ready pulse
i_mul_c  in  103  multiplier product
i_mul_c_en  in  1  multiplier product-valid pulse

Behaviour:
- Reset values: all outputs 0; RR pointer = N_REQ-1, so requester 0 has top priority first; tag FIFO empty; state IDLE.
- Reset mid-operation: all in-flight tags are discarded and no o_c_vld is produced. The multiplier shares i_rst.
- Issue FSM, two states:
  - IDLE: can_issue = 1.
  - WAIT_RDY: can_issue = i_mul_in_en.
- Transitions:
  - From either state, if can_issue and |i_req and the tag FIFO is not full: go to WAIT_RDY.
  - WAIT_RDY with i_mul_in_en and no request: go to IDLE.
- Arbitration, cycle t (when an issue occurs):
  - Winner = first requester with i_req set, scanning from pointer+1 with wrap.
  - Operands of the winner are registered.
  - Pointer is updated to the winner.
  - Winner's ID is pushed into the tag FIFO.
- Cycle t+1: o_mul_en = 1, o_mul_a/o_mul_b = registered operands, and o_gnt[winner] = 1, all for exactly one cycle.
- Requester handshake:
  - A requester may deassert i_req or change operands only in or after the cycle in which its o_gnt is high.
  - i_req still high in the o_gnt cycle is not re-granted, because the FSM is in WAIT_RDY.
- o_mul_a/o_mul_b hold their last value when no issue occurs.
- Result path: when i_mul_c_en is high, pop the tag. Next cycle: o_c = i_mul_c and o_c_vld[tag] = 1. o_c holds its value otherwise.
- Simultaneous push (issue) and pop (result) in one cycle are both performed; occupancy is unchanged.
- FIFO full: issue is blocked until a pop. A pop in the same cycle frees a slot for the issue.
- Result strobe with the FIFO empty: set o_err (cleared only by reset), drop the result, no o_c_vld.
- o_busy = (FIFO not empty) or (state == WAIT_RDY).
- Only one grant per issue; an i_mul_in_en pulse while in IDLE is ignored.

Decomposition:
- Shared package: MUL52_W = 52, MUL52_PW = 103, and requester ID width helper.
- One sub-module, sched_tag_fifo:
  - ID_W wide, TAG_DEPTH deep.
  - Push/pop in the same cycle.
  - Full/empty flags.
  - Async reset.
- The round-robin priority scan stays inline.

Test Plan:
- Single request: req0, a=3, b=-5 → o_gnt[0] one cycle after req, o_mul_en same cycle; after the multiplier finishes, o_c_vld[0] with o_c = -15 (103-bit sign-extended).
- All four requesters held high from reset:
  - Grant order 0,1,2,3,0.
  - Each grant after the first coincides with the cycle after i_mul_in_en.
  - Products (a=k+1, b=2^51-1) return to the matching o_c_vld index in order.
- Back-to-back saturation: continuous req1 and req2 → o_busy stays high; tag FIFO reaches 2 and never overflows; no o_err.
- Simultaneous i_mul_c_en and issue: FIFO holds 2 → push and pop in the same cycle; results are routed correctly.
- Reset mid-operation: assert i_rst 5 cycles after o_gnt[2] → all outputs 0 immediately; no o_c_vld afterwards; next req2 is served normally with the correct product.
- Spurious i_mul_c_en with no request pending → o_err = 1, o_c_vld stays 0.

Source files
------------

// File: rtl/mul52_rr_sched_pkg.sv
// Shared widths and types for the round-robin scheduler that fronts the
// 52x52 signed sequential multiplier.
package mul52_rr_sched_pkg;

    localparam int MUL52_W  = 52;
    localparam int MUL52_PW = 103;

    function automatic int req_id_w(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_RDY = 1'b1
    } sched_state_e;

endpackage

// File: rtl/mul52_rr_sched_tag_fifo.sv
// In-flight requester-ID FIFO; a pop in the same cycle makes room for a push
// even when full. Pops on an empty FIFO are ignored.
module sched_tag_fifo
    import mul52_rr_sched_pkg::*;
#(
    parameter int ID_W      = 2,
    parameter int TAG_DEPTH = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_push,
    input  logic [ID_W-1:0] i_push_id,
    input  logic            i_pop,
    output logic [ID_W-1:0] o_pop_id,
    output logic            o_full,
    output logic            o_empty
);

    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = $clog2(TAG_DEPTH + 1);

    logic [ID_W-1:0]  mem [TAG_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(TAG_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_full   = (count == CNT_W'(TAG_DEPTH));
    assign o_empty  = (count == '0);
    assign do_pop   = i_pop && !o_empty;
    assign do_push  = i_push && (!o_full || do_pop);
    assign o_pop_id = mem[rd_ptr];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= i_push_id;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mul52_rr_sched.sv
// Round-robin front end sharing one sequential 52x52 multiplier between
// N_REQ requesters, with tag-based routing of products back to their owner.
module mul52_rr_sched
    import mul52_rr_sched_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int ID_W      = req_id_w(N_REQ),
    parameter int TAG_DEPTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [MUL52_W*N_REQ-1:0] i_a_bus,
    input  logic [MUL52_W*N_REQ-1:0] i_b_bus,
    output logic [N_REQ-1:0]         o_gnt,
    output logic [MUL52_PW-1:0]      o_c,
    output logic [N_REQ-1:0]         o_c_vld,
    output logic                     o_busy,
    output logic                     o_err,
    output logic                     o_mul_en,
    output logic [MUL52_W-1:0]       o_mul_a,
    output logic [MUL52_W-1:0]       o_mul_b,
    input  logic                     i_mul_in_en,
    input  logic [MUL52_PW-1:0]      i_mul_c,
    input  logic                     i_mul_c_en
);

    // Handshake: i_req is a level held with stable operands until o_gnt; the
    // o_gnt pulse is the acceptance. The multiplier takes o_mul_en as a start
    // pulse, answers with i_mul_in_en when it can take the next operands, and
    // with i_mul_c_en when i_mul_c is valid. Products return in issue order.
    sched_state_e    state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] win_id;
    logic [ID_W-1:0] tag_id;
    logic            win_found;
    logic            can_issue;
    logic            issue;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;

    // Scan starts one past the last winner so every requester gets a turn.
    always_comb begin
        cand      = '0;
        win_id    = rr_ptr;
        win_found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = ID_W'((int'(rr_ptr) + i) % N_REQ);
            if (!win_found && i_req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign can_issue = (state == ST_IDLE) || i_mul_in_en;
    assign pop       = i_mul_c_en && !fifo_empty;
    assign issue     = can_issue && win_found && (!fifo_full || pop);
    assign o_busy    = !fifo_empty || (state == ST_WAIT_RDY);

    sched_tag_fifo #(
        .ID_W      (ID_W),
        .TAG_DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_push    (issue),
        .i_push_id (win_id),
        .i_pop     (i_mul_c_en),
        .o_pop_id  (tag_id),
        .o_full    (fifo_full),
        .o_empty   (fifo_empty)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            rr_ptr   <= ID_W'(N_REQ - 1);
            o_gnt    <= '0;
            o_mul_en <= 1'b0;
            o_mul_a  <= '0;
            o_mul_b  <= '0;
            o_c      <= '0;
            o_c_vld  <= '0;
            o_err    <= 1'b0;
        end else begin
            o_gnt    <= '0;
            o_c_vld  <= '0;
            o_mul_en <= issue;
            if (issue) begin
                state          <= ST_WAIT_RDY;
                rr_ptr         <= win_id;
                o_gnt[win_id]  <= 1'b1;
                o_mul_a        <= i_a_bus[int'(win_id)*MUL52_W +: MUL52_W];
                o_mul_b        <= i_b_bus[int'(win_id)*MUL52_W +: MUL52_W];
            end else if (state == ST_WAIT_RDY && i_mul_in_en && !win_found) begin
                state <= ST_IDLE;
            end
            // A product with no owner is dropped and flagged until reset.
            if (pop) begin
                o_c             <= i_mul_c;
                o_c_vld[tag_id] <= 1'b1;
            end else if (i_mul_c_en) begin
                o_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mul52_rr_sched.sv
// Bench for mul52_rr_sched: behavioural 9-pass multiplier, spec-level
// scheduler reference with an expected-result queue, and directed corners.
module tb_mul52_rr_sched;

    localparam int N      = 4;
    localparam int W      = 52;
    localparam int PW     = 103;
    localparam int PASSES = 9;

    logic            i_clk;
    logic            i_rst;
    logic [N-1:0]    i_req;
    logic [W*N-1:0]  i_a_bus;
    logic [W*N-1:0]  i_b_bus;
    logic [N-1:0]    o_gnt;
    logic [PW-1:0]   o_c;
    logic [N-1:0]    o_c_vld;
    logic            o_busy;
    logic            o_err;
    logic            o_mul_en;
    logic [W-1:0]    o_mul_a;
    logic [W-1:0]    o_mul_b;
    logic            i_mul_in_en;
    logic [PW-1:0]   i_mul_c;
    logic            i_mul_c_en;

    logic            m_in_en;
    logic            m_c_en;
    logic [PW-1:0]   m_c;
    logic            inj_c_en;
    int              mul_lat;

    int checks = 0;
    int errors = 0;

    assign i_mul_in_en = m_in_en;
    assign i_mul_c     = m_c;
    assign i_mul_c_en  = m_c_en | inj_c_en;

    mul52_rr_sched #(.N_REQ(N), .ID_W(2), .TAG_DEPTH(2)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_req),
        .i_a_bus     (i_a_bus),
        .i_b_bus     (i_b_bus),
        .o_gnt       (o_gnt),
        .o_c         (o_c),
        .o_c_vld     (o_c_vld),
        .o_busy      (o_busy),
        .o_err       (o_err),
        .o_mul_en    (o_mul_en),
        .o_mul_a     (o_mul_a),
        .o_mul_b     (o_mul_b),
        .i_mul_in_en (i_mul_in_en),
        .i_mul_c     (i_mul_c),
        .i_mul_c_en  (i_mul_c_en)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [PW-1:0] sa;
        logic signed [PW-1:0] sb;
        sa = {{(PW-W){a[W-1]}}, a};
        sb = {{(PW-W){b[W-1]}}, b};
        return sa * sb;
    endfunction

    // ---------------- multiplier model ----------------
    // One operand set computes for PASSES cycles, then its product waits
    // mul_lat further cycles in an output stage before i_mul_c_en.
    int unsigned     cyc;
    int unsigned     rdy_due;
    bit              comp_busy;
    logic [PW-1:0]   comp_c;
    logic [PW+31:0]  res_q[$];

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cyc = 0;
            comp_busy = 1'b0;
            res_q.delete();
            m_in_en <= 1'b0;
            m_c_en  <= 1'b0;
            m_c     <= '0;
        end else begin
            cyc = cyc + 1;
            m_in_en <= 1'b0;
            m_c_en  <= 1'b0;
            if (o_mul_en) begin
                comp_busy = 1'b1;
                rdy_due   = cyc + PASSES - 1;
                comp_c    = prod(o_mul_a, o_mul_b);
            end
            if (comp_busy && rdy_due == cyc) begin
                m_in_en <= 1'b1;
                comp_busy = 1'b0;
                res_q.push_back({32'(cyc + mul_lat), comp_c});
            end
            if (res_q.size() > 0 && res_q[0][PW+31:PW] == cyc) begin
                m_c_en <= 1'b1;
                m_c    <= res_q[0][PW-1:0];
                void'(res_q.pop_front());
            end
        end
    end

    // ---------------- scoreboard / reference ----------------
    logic [PW+1:0]   exp_q[$];   // {requester id, product} in issue order
    logic [N-1:0]    exp_gnt;
    logic [N-1:0]    exp_vld;
    logic [W-1:0]    exp_a;
    logic [W-1:0]    exp_b;
    logic [PW-1:0]   exp_c;
    bit              exp_busy;
    bit              exp_err;
    bit              ref_idle;
    int              last_win;
    int              gnt_log[$];
    int              coinc_cnt;

    always @(negedge i_clk) begin
        int           n_before;
        bit           pop_ok;
        bit           issue;
        int           w;
        logic [PW+1:0] r;
        if (i_rst) begin
            exp_q.delete();
            exp_gnt  = '0;
            exp_vld  = '0;
            exp_busy = 1'b0;
            exp_err  = 1'b0;
            ref_idle = 1'b1;
            last_win = N - 1;
        end else begin
            chk("gnt", 128'(o_gnt), 128'(exp_gnt));
            chk("mul_en", 128'(o_mul_en), 128'(|exp_gnt));
            if (|exp_gnt) begin
                chk("mul_a", 128'(o_mul_a), 128'(exp_a));
                chk("mul_b", 128'(o_mul_b), 128'(exp_b));
            end
            chk("c_vld", 128'(o_c_vld), 128'(exp_vld));
            if (|exp_vld) chk("c", 128'(o_c), 128'(exp_c));
            chk("busy", 128'(o_busy), 128'(exp_busy));
            chk("err", 128'(o_err), 128'(exp_err));
            for (int k = 0; k < N; k++) if (o_gnt[k]) gnt_log.push_back(k);

            // Expectations for the next clock edge.
            n_before = exp_q.size();
            pop_ok   = i_mul_c_en && (n_before > 0);
            issue    = (ref_idle || i_mul_in_en) && (i_req != '0) && (n_before < 2 || pop_ok);
            exp_vld  = '0;
            exp_gnt  = '0;
            if (pop_ok) begin
                r = exp_q.pop_front();
                exp_vld[r[PW+1:PW]] = 1'b1;
                exp_c = r[PW-1:0];
            end else if (i_mul_c_en) begin
                exp_err = 1'b1;
            end
            if (issue) begin
                w = last_win;
                for (int s = 1; s <= N; s++) begin
                    if (i_req[(last_win + s) % N]) begin
                        w = (last_win + s) % N;
                        break;
                    end
                end
                last_win   = w;
                exp_gnt[w] = 1'b1;
                exp_a      = i_a_bus[w*W +: W];
                exp_b      = i_b_bus[w*W +: W];
                exp_q.push_back({2'(w), prod(exp_a, exp_b)});
                ref_idle   = 1'b0;
                if (pop_ok && n_before == 2) coinc_cnt++;
            end else if (i_mul_in_en && i_req == '0) begin
                ref_idle = 1'b1;
            end
            exp_busy = (exp_q.size() > 0) || !ref_idle;
        end
    end

    // ---------------- driver tasks ----------------
    typedef struct {
        int          id;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [PW-1:0] c;
    } vec_t;

    vec_t vec[6];

    task automatic set_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
        i_a_bus[k*W +: W] = a;
        i_b_bus[k*W +: W] = b;
    endtask

    task automatic set_rand_op(input int k);
        logic [63:0] t;
        logic [W-1:0] v [2];
        for (int j = 0; j < 2; j++) begin
            t = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0:       v[j] = {1'b1, {(W-1){1'b0}}};
                1:       v[j] = {1'b0, {(W-1){1'b1}}};
                2:       v[j] = '1;
                default: v[j] = t[W-1:0];
            endcase
        end
        set_op(k, v[0], v[1]);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},    128'(o_gnt),    128'(0));
        chk({tag, "_c"},      128'(o_c),      128'(0));
        chk({tag, "_c_vld"},  128'(o_c_vld),  128'(0));
        chk({tag, "_busy"},   128'(o_busy),   128'(0));
        chk({tag, "_err"},    128'(o_err),    128'(0));
        chk({tag, "_mul_en"}, 128'(o_mul_en), 128'(0));
        chk({tag, "_mul_a"},  128'(o_mul_a),  128'(0));
        chk({tag, "_mul_b"},  128'(o_mul_b),  128'(0));
    endtask

    // Single request from an idle scheduler: grant after one cycle, then the
    // product on that requester's strobe.
    task automatic run_vec(input vec_t v);
        int  n;
        bit  seen;
        set_op(v.id, v.a, v.b);
        i_req[v.id] = 1'b1;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 50) begin
            @(posedge i_clk); #1;
            n++;
            if (o_gnt[v.id]) begin
                seen = 1'b1;
                i_req[v.id] = 1'b0;
            end
        end
        chk("vec_gnt_latency", 128'(n), 128'(1));
        seen = 1'b0;
        n = 0;
        while (!seen && n < 60) begin
            @(posedge i_clk); #1;
            n++;
            if (o_c_vld != '0) seen = 1'b1;
        end
        chk("vec_vld_onehot", 128'(o_c_vld), 128'(1) << v.id);
        chk("vec_product", 128'(o_c), 128'(v.c));
        repeat (3) @(posedge i_clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int busy_low;
        int vld_seen;
        bit started;
        vec_t rv;

        i_rst = 1'b1;
        i_req = '0;
        i_a_bus = '0;
        i_b_bus = '0;
        inj_c_en = 1'b0;
        mul_lat = 3;
        coinc_cnt = 0;

        vec[0] = '{id: 0, a: 52'd3, b: 52'd0 - 52'd5, c: 103'd0 - 103'd15};
        vec[1] = '{id: 1, a: {1'b0, {51{1'b1}}}, b: {1'b0, {51{1'b1}}},
                   c: (103'd1 << 102) - (103'd1 << 52) + 103'd1};
        vec[2] = '{id: 2, a: {1'b1, {51{1'b0}}}, b: {1'b1, {51{1'b0}}}, c: 103'd1 << 102};
        vec[3] = '{id: 3, a: 52'd0 - 52'd1, b: 52'd1, c: 103'd0 - 103'd1};
        vec[4] = '{id: 1, a: 52'd0, b: 52'd12345, c: 103'd0};
        vec[5] = '{id: 2, a: {1'b1, {51{1'b0}}}, b: {1'b0, {51{1'b1}}},
                   c: (103'd1 << 102) + (103'd1 << 51)};

        repeat (3) @(posedge i_clk);
        #1;
        chk_all_zero("reset");
        i_rst = 1'b0;

        // Table of single operations.
        for (int v = 0; v < 6; v++) run_vec(vec[v]);

        // All four requesting from reset: strict rotation 0,1,2,3,0.
        i_rst = 1'b1;
        gnt_log.delete();
        for (int k = 0; k < N; k++) set_op(k, W'(k + 1), {1'b0, {(W-1){1'b1}}});
        i_req = '1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        n = 0;
        while (gnt_log.size() < 5 && n < 200) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk("rr_grant_count", 128'(gnt_log.size() >= 5), 128'(1));
        if (gnt_log.size() >= 5) begin
            chk("rr_order0", 128'(gnt_log[0]), 128'(0));
            chk("rr_order1", 128'(gnt_log[1]), 128'(1));
            chk("rr_order2", 128'(gnt_log[2]), 128'(2));
            chk("rr_order3", 128'(gnt_log[3]), 128'(3));
            chk("rr_order4", 128'(gnt_log[4]), 128'(0));
        end
        i_req = '0;
        repeat (40) @(posedge i_clk);
        #1;

        // Saturation with the longest output stage: results pop as the
        // next operation issues while two are in flight.
        mul_lat = 10;
        coinc_cnt = 0;
        set_rand_op(1);
        set_rand_op(2);
        i_req = 4'b0110;
        busy_low = 0;
        started = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge i_clk); #1;
            if (started && !o_busy) busy_low++;
            if (o_gnt != '0) started = 1'b1;
            for (int k = 1; k <= 2; k++) if (o_gnt[k]) set_rand_op(k);
        end
        chk("sat_busy_low_cycles", 128'(busy_low), 128'(0));
        chk("sat_push_pop_coincide", 128'(coinc_cnt > 0), 128'(1));
        chk("sat_no_err", 128'(o_err), 128'(0));
        i_req = '0;
        repeat (60) @(posedge i_clk);
        #1;

        // Reset five cycles after a grant: tags discarded, no strobe.
        mul_lat = 3;
        rv = '{id: 2, a: 52'd7, b: 52'd0 - 52'd9, c: 103'd0 - 103'd63};
        set_op(2, rv.a, rv.b);
        i_req[2] = 1'b1;
        n = 0;
        while (!o_gnt[2] && n < 50) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk("rstmid_gnt_seen", 128'(o_gnt[2]), 128'(1));
        i_req[2] = 1'b0;
        repeat (5) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        #1;
        chk_all_zero("rstmid");
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        vld_seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge i_clk); #1;
            if (o_c_vld != '0) vld_seen++;
        end
        chk("rstmid_no_vld", 128'(vld_seen), 128'(0));
        run_vec(rv);

        // Randomised traffic against the reference.
        for (int c = 0; c < 1500; c++) begin
            @(posedge i_clk); #1;
            mul_lat = $urandom_range(1, 10);
            for (int k = 0; k < N; k++) begin
                if (i_req[k] && o_gnt[k]) begin
                    if ($urandom_range(0, 1) == 1) i_req[k] = 1'b0;
                    else set_rand_op(k);
                end else if (!i_req[k] && $urandom_range(0, 3) == 0) begin
                    set_rand_op(k);
                    i_req[k] = 1'b1;
                end
            end
        end
        i_req = '0;
        repeat (60) @(posedge i_clk);
        #1;
        chk("rand_no_err", 128'(o_err), 128'(0));

        // Product strobe with nothing in flight.
        inj_c_en = 1'b1;
        @(posedge i_clk); #1;
        inj_c_en = 1'b0;
        chk("spurious_err_set", 128'(o_err), 128'(1));
        chk("spurious_no_vld", 128'(o_c_vld), 128'(0));
        repeat (5) @(posedge i_clk);
        #1;
        chk("spurious_err_sticky", 128'(o_err), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
